// File: rtl/gray_seq_monitor_if.sv
// gray_seq_monitor_if: sample stream in, validated binary position and integrity status out
interface gray_seq_monitor_if #(
  parameter int W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [W-1:0]     grey_in;
  logic             clear_err;
  logic [W-1:0]     bin_out;
  logic             bin_valid;
  logic             step_ok;
  logic             step_err;
  logic             dir;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] err_count;
  modport master (
    output in_valid, grey_in, clear_err,
    input  bin_out, bin_valid, step_ok, step_err, dir, locked, fault, err_count
  );
  modport slave (
    input  in_valid, grey_in, clear_err,
    output bin_out, bin_valid, step_ok, step_err, dir, locked, fault, err_count
  );
endinterface

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: converts gray samples to binary, classifies transitions, tracks lock and error counts
module gray_seq_monitor #(
  parameter int W = 4,
  parameter int ACQ_STEPS = 2,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  gray_seq_monitor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2, FAULT = 2'd3;
  localparam int GW = $clog2(ACQ_STEPS + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [GW-1:0] ACQ_N = GW'(ACQ_STEPS);
  localparam logic [EW-1:0] ERR_N = EW'(ERR_LIMIT);
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [1:0]       state_q, state_d;
  logic [W-1:0]     prev_g_q, bin_out_q, bin_new, diff;
  logic [GW-1:0]    good_q, good_d;
  logic [EW-1:0]    cerr_q, cerr_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             bin_valid_q, step_ok_q, step_err_q, dir_q;
  logic             is_step, is_err, up;
  always_comb begin
    bin_new = g2b(bus.grey_in);
    diff    = bus.grey_in ^ prev_g_q;
    is_step = bus.in_valid && state_q != IDLE && $countones(diff) == 1;
    is_err  = bus.in_valid && state_q != IDLE && $countones(diff) > 1;
    up      = bin_new == g2b(prev_g_q) + W'(1);
    err_d   = bus.clear_err ? '0 : (is_err && !(&err_q)) ? err_q + 1'b1 : err_q;
    state_d = state_q;
    good_d  = good_q;
    cerr_d  = cerr_q;
    case (state_q)
      IDLE:   state_d = bus.in_valid ? ACQ : IDLE;
      ACQ: begin
        good_d  = is_err ? '0 : is_step ? good_q + 1'b1 : good_q;
        state_d = good_d == ACQ_N ? LOCKED : ACQ;
      end
      LOCKED: begin
        cerr_d  = is_step ? '0 : is_err ? cerr_q + 1'b1 : cerr_q;
        state_d = cerr_d == ERR_N ? FAULT : LOCKED;
      end
      default: state_d = bus.clear_err ? ACQ : FAULT;
    endcase
    // every state entry starts both run counters from zero
    if (state_d != state_q) begin
      good_d = '0;
      cerr_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_g_q    <= '0;
      bin_out_q   <= '0;
      good_q      <= '0;
      cerr_q      <= '0;
      err_q       <= '0;
      bin_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_err_q  <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      cerr_q      <= cerr_d;
      err_q       <= err_d;
      bin_valid_q <= bus.in_valid;
      step_ok_q   <= is_step;
      step_err_q  <= is_err;
      if (bus.in_valid) begin
        prev_g_q  <= bus.grey_in;
        bin_out_q <= bin_new;
      end
      if (is_step) dir_q <= up;
    end
  end
  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.step_ok   = step_ok_q;
  assign bus.step_err  = step_err_q;
  assign bus.dir       = dir_q;
  assign bus.locked    = state_q == LOCKED;
  assign bus.fault     = state_q == FAULT;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_gray_seq_monitor.sv
// tb_gray_seq_monitor: directed stimulus checked against a behavioural model plus hand-computed literals
module tb_gray_seq_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  gray_seq_monitor_if #(.W(4), .CNT_W(8)) bus ();
  gray_seq_monitor #(.W(4), .ACQ_STEPS(2), .ERR_LIMIT(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: mode 0 = no reference, 1 = acquiring, 2 = locked, 3 = faulted
  bit         mv = 1'b0;
  int         m_mode, m_good, m_bad, m_ec, m_bin;
  logic [3:0] m_pg;
  bit         m_bv, m_ok, m_er, m_dir;
  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < 4; s++) b ^= g >> s;
    return b & 15;
  endfunction
  task automatic model_step();
    int pm, b, d;
    if (rst) begin
      mv = 1'b1; m_mode = 0; m_good = 0; m_bad = 0; m_ec = 0; m_bin = 0;
      m_pg = 4'd0; m_bv = 0; m_ok = 0; m_er = 0; m_dir = 0;
      return;
    end
    pm = m_mode;
    m_bv = bus.in_valid; m_ok = 0; m_er = 0;
    if (bus.in_valid) begin
      b = g2b(int'(bus.grey_in));
      if (pm != 0) begin
        d = $countones(bus.grey_in ^ m_pg);
        if (d == 1) begin
          m_ok = 1;
          m_dir = ((b - g2b(int'(m_pg))) & 15) == 1;
        end
        if (d >= 2) m_er = 1;
      end
      m_bin = b;
      m_pg = bus.grey_in;
    end
    if (bus.clear_err) m_ec = 0;
    else if (m_er && m_ec < 255) m_ec++;
    if (pm == 0 && bus.in_valid) begin m_mode = 1; m_good = 0; m_bad = 0; end
    else if (pm == 1) begin
      if (m_ok) m_good++;
      if (m_er) m_good = 0;
      if (m_good == 2) begin m_mode = 2; m_good = 0; m_bad = 0; end
    end else if (pm == 2) begin
      if (m_er) m_bad++;
      if (m_ok) m_bad = 0;
      if (m_bad == 3) begin m_mode = 3; m_good = 0; m_bad = 0; end
    end else if (pm == 3 && bus.clear_err) begin m_mode = 1; m_good = 0; m_bad = 0; end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    if (mv) begin
      chk("m_bin_out", bus.bin_out, m_bin);
      chk("m_bin_valid", bus.bin_valid, m_bv);
      chk("m_step_ok", bus.step_ok, m_ok);
      chk("m_step_err", bus.step_err, m_er);
      chk("m_dir", bus.dir, m_dir);
      chk("m_locked", bus.locked, m_mode == 2);
      chk("m_fault", bus.fault, m_mode == 3);
      chk("m_err_count", bus.err_count, m_ec);
    end
  end
  task automatic drive(input logic v, input logic [3:0] g, input logic c = 1'b0);
    bus.in_valid = v; bus.grey_in = g; bus.clear_err = c;
    @(negedge clk);
  endtask
  logic [3:0] g;
  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.grey_in = 4'd0; bus.clear_err = 1'b0;
    drive(0, 0); drive(0, 0);
    chk("rst_bin_valid", bus.bin_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_count", bus.err_count, 0);
    rst = 1'b0;
    drive(1, 4'b0000); chk("up0_bin", bus.bin_out, 0); chk("up0_ok", bus.step_ok, 0); chk("up0_bv", bus.bin_valid, 1);
    drive(1, 4'b0001); chk("up1_bin", bus.bin_out, 1); chk("up1_ok", bus.step_ok, 1); chk("up1_dir", bus.dir, 1); chk("up1_lock", bus.locked, 0);
    drive(1, 4'b0011); chk("up2_bin", bus.bin_out, 2); chk("up2_lock", bus.locked, 1);
    drive(1, 4'b0010); chk("up3_bin", bus.bin_out, 3); chk("up3_ok", bus.step_ok, 1);
    drive(0, 0);
    drive(1, 4'b0010); chk("hold_bin", bus.bin_out, 3); chk("hold_ok", bus.step_ok, 0); chk("hold_err", bus.step_err, 0); chk("hold_lock", bus.locked, 1);
    drive(0, 0); drive(0, 0);
    drive(1, 4'b0010); chk("hold2_bv", bus.bin_valid, 1); chk("hold2_lock", bus.locked, 1);
    drive(0, 0); chk("gap_bv", bus.bin_valid, 0); chk("gap_bin", bus.bin_out, 3);
    for (int i = 4; i < 16; i++) drive(1, 4'(i ^ (i >> 1)));
    chk("top_bin", bus.bin_out, 15); chk("top_lock", bus.locked, 1);
    drive(1, 4'b0000); chk("wrap_bin", bus.bin_out, 0); chk("wrap_ok", bus.step_ok, 1); chk("wrap_dir", bus.dir, 1);
    drive(1, 4'b1000); chk("rev_bin", bus.bin_out, 15); chk("rev_ok", bus.step_ok, 1); chk("rev_dir", bus.dir, 0);
    drive(1, 4'b0000); drive(1, 4'b0001); drive(1, 4'b0011);
    drive(1, 4'b0110); chk("e1_err", bus.step_err, 1); chk("e1_cnt", bus.err_count, 1); chk("e1_lock", bus.locked, 1);
    drive(1, 4'b0000); chk("e2_cnt", bus.err_count, 2);
    drive(1, 4'b0011); chk("e3_cnt", bus.err_count, 3); chk("e3_fault", bus.fault, 1); chk("e3_lock", bus.locked, 0);
    drive(1, 4'b0101, 1); chk("clr_cnt", bus.err_count, 0); chk("clr_err", bus.step_err, 1); chk("clr_fault", bus.fault, 0); chk("clr_lock", bus.locked, 0);
    drive(1, 4'b0100); chk("acq1_bin", bus.bin_out, 7); chk("acq1_lock", bus.locked, 0);
    drive(1, 4'b1100); chk("acq2_bin", bus.bin_out, 8); chk("acq2_lock", bus.locked, 1);
    g = 4'b1100;
    repeat (5) begin
      g ^= 4'b0011; drive(1, g);
      g ^= 4'b0100; drive(1, g);
    end
    chk("five_cnt", bus.err_count, 5); chk("five_lock", bus.locked, 1);
    rst = 1'b1; drive(1, 4'b1111); rst = 1'b0;
    chk("mrst_bv", bus.bin_valid, 0); chk("mrst_bin", bus.bin_out, 0); chk("mrst_cnt", bus.err_count, 0); chk("mrst_lock", bus.locked, 0);
    drive(1, 4'b0110); chk("ref_bv", bus.bin_valid, 1); chk("ref_bin", bus.bin_out, 4); chk("ref_ok", bus.step_ok, 0); chk("ref_lock", bus.locked, 0);
    repeat (130) begin drive(1, 4'b0000); drive(1, 4'b0011); end
    chk("sat_cnt", bus.err_count, 255); chk("sat_lock", bus.locked, 0);
    drive(0, 0, 1); chk("acqclr_cnt", bus.err_count, 0); chk("acqclr_fault", bus.fault, 0);
    drive(0, 0); drive(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_seq_monitor.md
# gray_seq_monitor

Downstream consumer of the free-running 4-bit gray-code stream. It registers each valid gray sample, converts it to binary, and classifies every transition against the previous sample: hold, legal single-bit step up or down, or illegal multi-bit jump. It tracks lock status with an acquire/locked/fault state machine and keeps a saturating error count. It sits between the gray-code source and any logic that needs validated binary position or integrity status.

## Interface
- W, 4, gray/binary width (>=2)
- ACQ_STEPS, 2, consecutive good steps required to lock
- ERR_LIMIT, 3, consecutive errors in LOCKED that force FAULT
- CNT_W, 8, err_count width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  grey_in is a sample this cycle
- grey_in  in  W  gray-code sample
- clear_err  in  1  clear err_count; leave FAULT
- bin_out  out  W  binary of last accepted sample
- bin_valid  out  1  one-cycle pulse, bin_out/flags updated
- step_ok  out  1  with bin_valid: legal single-bit step
- step_err  out  1  with bin_valid: Hamming distance >= 2
- dir  out  1  direction of last legal step (1 = +1, 0 = -1)
- locked  out  1  state == LOCKED
- fault  out  1  state == FAULT
- err_count  out  CNT_W  total step_err events, saturating

## Operation
- Conversion: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0. Combinational within the cycle, registered into bin_out.
- Classification uses d = popcount(grey_in ^ prev_g):
  - d = 0 is hold.
  - d = 1 is a step. dir = 1 if bin_new == bin_prev + 1 mod 2^W, else 0.
  - d >= 2 is an error.
- prev_g updates on every accepted sample, including error samples, so the next sample compares against the newest one.
- States:
  - IDLE: no reference sample held. First in_valid stores prev_g, pulses bin_valid with step_ok = step_err = 0, and moves to ACQ.
  - ACQ: a step increments good_cnt. An error sets good_cnt = 0. A hold leaves it unchanged. When good_cnt reaches ACQ_STEPS, move to LOCKED.
  - LOCKED: an error increments cerr_cnt. A step clears cerr_cnt. A hold leaves it unchanged. When cerr_cnt reaches ERR_LIMIT, move to FAULT.
  - FAULT: conversion and classification continue; the state holds until clear_err, which moves to ACQ with good_cnt = 0.
- good_cnt and cerr_cnt are cleared on every state entry.
- err_count increments on every step_err in ACQ, LOCKED and FAULT, and saturates at 2^CNT_W-1.
- clear_err:
  - Zeroes err_count in any state.
  - If a step_err coincides with clear_err, clear wins and err_count = 0.
  - In IDLE, ACQ or LOCKED it changes no state.
- in_valid = 0: no update. bin_valid = 0, step_ok = 0, step_err = 0, and all other outputs hold.

## Timing
- Latency: sample at edge N (in_valid = 1) produces bin_out, bin_valid, step_ok, step_err and dir valid after edge N+1.
- locked and fault change on the same edge as the bin_valid of the causing sample.
- Back-to-back in_valid is supported every cycle. Throughput is 1 sample per clock.
- Reset values, forced on the edge where rst = 1, override everything:
  - Outputs: bin_out = 0, bin_valid = 0, step_ok = 0, step_err = 0, dir = 0, locked = 0, fault = 0, err_count = 0.
  - Internal: state = IDLE, prev_g = 0, good_cnt = 0, cerr_cnt = 0.
- Reset mid-stream: a sample presented during reset is discarded. The first sample after reset is treated as the IDLE reference.
- Wrap: gray 1000 -> 0000 (bin 15 -> 0) is a legal step with dir = 1. The reverse (0000 -> 1000) is legal with dir = 0.

## Test plan
- Count up: after reset, feed 0000, 0001, 0011, 0010 with in_valid every cycle -> bin_out 0, 1, 2, 3. step_ok = 0, 1, 1, 1. dir = 1. locked rises with bin_out = 2.
- Wrap and reverse: when locked at 1000 (bin 15), feed 0000 -> bin 0, step_ok, dir = 1. Then feed 1000 -> bin 15, step_ok, dir = 0.
- Errors to fault: when locked at 0011, feed 0110, 0000, 0011 -> three step_err pulses, err_count 1, 2, 3. fault = 1 and locked = 0 with the third error.
- Hold and gaps: when locked at 0010, feed 0010 twice with idle cycles between -> bin_valid pulses with bin_out = 3, no step_ok/step_err, cerr_cnt unchanged, still locked.
- Clear: in FAULT with err_count = 3, pulse clear_err together with an error sample -> err_count = 0, state ACQ. Two further good steps -> locked = 1.
- Reset mid-operation: when locked with err_count = 5, assert rst for 1 cycle -> all outputs 0. The next sample acts as the IDLE reference: step_ok = 0, locked = 0.
